// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Read data is registered, so a popped word appears one clock after the pop.
module fifo_param #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_DEFAULT = 6,
    parameter int unsigned AE_DEFAULT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   umbral_AF_in,
    input  logic [ADDR_WIDTH:0]   umbral_AE_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         af_thr_q, af_thr_d;
    logic [CW-1:0]         ae_thr_q, ae_thr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  push_ok, pop_ok;

    // Flags decode the registered count, so they follow the causing edge by one cycle.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_thr_q);
    assign almost_empty = (count_q <= ae_thr_q);

    assign count         = count_q;
    assign data_out      = data_out_q;
    assign valid_out     = valid_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

    // A pop frees the slot the push needs, so a full FIFO accepts push+pop together.
    always_comb begin
        push_ok    = push && (!full || pop);
        pop_ok     = pop && !empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q | (push && full && !pop);
        unf_d      = unf_q | (pop && empty);
        af_thr_d   = init ? umbral_AF_in : af_thr_q;
        ae_thr_d   = init ? umbral_AE_in : ae_thr_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d = mem[rd_ptr_q];
            valid_d    = 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            af_thr_q   <= CW'(AF_DEFAULT);
            ae_thr_q   <= CW'(AE_DEFAULT);
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            af_thr_q   <= af_thr_d;
            ae_thr_q   <= ae_thr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage array carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO for the PCIe transaction-layer datapath. It is the next-generation replacement for the fixed 12-bit x 8 FIFO, with configurable width and depth.
- Adds true full/empty flags, independent almost-full/almost-empty flags and an occupancy count.
- Adds sticky overflow/underflow error flags.
- Handles simultaneous push and pop correctly in every fill state.
- Sits between the per-class referee/arbiter logic and the transmit path; one instance per virtual channel.

Parameters:
DATA_WIDTH, 12, width of each stored word
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8 entries)
AF_DEFAULT, 6, almost-full threshold loaded at reset
AE_DEFAULT, 1, almost-empty threshold loaded at reset

Ports:
clk  input  1  single clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
init  input  1  when high, load threshold inputs into internal threshold registers
umbral_AF_in  input  ADDR_WIDTH+1  almost-full threshold (entries)
umbral_AE_in  input  ADDR_WIDTH+1  almost-empty threshold (entries)
push  input  1  write request; data_in is captured on the same edge
pop  input  1  read request
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  registered read data
valid_out  output  1  one-cycle pulse: data_out holds a newly popped word
full, empty  output  1  count==DEPTH / count==0
almost_full, almost_empty  output  1  threshold flags
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow_err, underflow_err  output  1  sticky error flags

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values (while reset is high):
  - wr_ptr = rd_ptr = 0; count = 0; data_out = 0; valid_out = 0.
  - empty = 1, full = 0, almost_full = 0, almost_empty = 1.
  - Both error flags = 0.
  - Thresholds load AF_DEFAULT and AE_DEFAULT.
  - Memory contents are don't-care.
  - reset overrides push, pop and init in the same cycle. A reset asserted mid-operation discards all stored entries.
- Storage: DEPTH x DATA_WIDTH register array. Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0. count is maintained separately (ADDR_WIDTH+1 bits).
- Push accepted (push && (!full || pop)):
  - mem[wr_ptr] <= data_in; wr_ptr++.
- Pop accepted (pop && !empty):
  - data_out <= mem[rd_ptr]; rd_ptr++; valid_out = 1 next cycle.
  - Read latency: 1 clock. No fall-through.
- When no pop is accepted: valid_out = 0 and data_out holds its previous value.
- count update:
  - +1 for push-only accepted.
  - -1 for pop-only accepted.
  - Unchanged when both are accepted or neither is.
- Simultaneous events:
  - push+pop while full: both accepted; count stays DEPTH; oldest word is output.
  - push+pop while empty: push accepted; pop rejected; underflow_err set; count -> 1; valid_out = 0.
  - push+pop at 0 < count < DEPTH: both accepted; count unchanged.
- Errors:
  - push while full without pop: write dropped; memory and pointers unchanged; overflow_err <= 1.
  - pop while empty: underflow_err <= 1.
  - Both error flags are sticky until reset.
- Flags are combinational from the registered count and thresholds, so they are valid the cycle after the causing edge:
  - full = (count == DEPTH); empty = (count == 0).
  - almost_full = (count >= umbral_AF); almost_empty = (count <= umbral_AE).
  - The two almost flags are evaluated independently; both may be high at once.
- init: thresholds register from the inputs on the edge where init is high. Push/pop operate normally in the same cycle. New thresholds affect the flags from the next cycle.
- Threshold values > DEPTH are accepted unchanged. Resulting behaviour: almost_full never asserts; almost_empty is always high.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, full=0, data_out=0, errors=0.
- Push 8 words 0x001..0x008 -> count=8, full=1, almost_full high once count=6; a 9th push -> data dropped, overflow_err=1, count=8.
- From full, pop 8 times -> data_out returns 0x001..0x008 one cycle after each pop, valid_out pulses each time, empty=1 at end. A 9th pop -> underflow_err=1, valid_out=0, data_out holds 0x008.
- Wrap-around: push 5, pop 5, push 6, pop 6 -> output order preserved across the pointer wrap; count returns to 0.
- Simultaneous push+pop at count=8 with data_in=0xABC -> count stays 8 and the oldest word is output; at count=0 -> count=1, underflow_err=1, and 0xABC is read by the next pop.
- init with umbral_AF_in=3, umbral_AE_in=2; push 3 -> almost_empty high through count=2; almost_full first high at count=3. Assert reset at count=3 -> count=0, thresholds back to 6/1.
